// File: rtl/viterbi_ber_monitor.sv
// rtl/viterbi_ber_monitor.sv - in-line BER scoreboard for a Viterbi decode chain
//
// Buffers every original bit fed to the encoder, realigns it to the decoded
// stream by a latched latency Lq, and counts good/bad compares (saturating).
// It also records the original-bit index of the first mismatch.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   enable_i            stream advance (data_i / dec_i valid)
//   data_i, dec_i       original bit, decoded bit
//   latency_i           decoder latency in enable cycles, latched on leaving IDLE
//   clear_i             synchronous clear back to IDLE
//   good_ct_o/bad_ct_o  saturating compare counters
//   word_ct_o           enable cycles since leaving IDLE (wraps)
//   cmp_valid_o, err_o  one-cycle pulses following each compare
//   first_err_o/_vld_o  index of first mismatch, sticky valid
//   sat_o               sticky, a counter reached all-ones
module viterbi_ber_monitor #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              data_i,
  input  logic              dec_i,
  input  logic [ADDR_W-1:0] latency_i,
  input  logic              clear_i,
  output logic [CNT_W-1:0]  good_ct_o,
  output logic [CNT_W-1:0]  bad_ct_o,
  output logic [CNT_W-1:0]  word_ct_o,
  output logic              cmp_valid_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  first_err_o,
  output logic              first_err_vld_o,
  output logic              sat_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAT_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, CHECK} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] lq_q, lq_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  good_q, good_d;
  logic [CNT_W-1:0]  bad_q, bad_d;
  logic [CNT_W-1:0]  word_q, word_d;
  logic [CNT_W-1:0]  first_q, first_d;
  logic              first_vld_q, first_vld_d;
  logic              sat_q, sat_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic              err_q, err_d;

  logic              mem [DEPTH];
  logic              we;
  logic              do_cmp;
  logic              ref_bit;
  logic              mismatch;
  logic [ADDR_W-1:0] lq_eff;

  always_comb begin
    state_d     = state_q;
    lq_d        = lq_q;
    wr_ptr_d    = wr_ptr_q;
    good_d      = good_q;
    bad_d       = bad_q;
    word_d      = word_q;
    first_d     = first_q;
    first_vld_d = first_vld_q;
    sat_d       = sat_q;
    cmp_valid_d = 1'b0;
    err_d       = 1'b0;
    we          = 1'b0;
    do_cmp      = 1'b0;
    ref_bit     = 1'b0;
    mismatch    = 1'b0;
    lq_eff      = lq_q;

    if (clear_i) begin
      state_d     = IDLE;
      lq_d        = '0;
      wr_ptr_d    = '0;
      good_d      = '0;
      bad_d       = '0;
      word_d      = '0;
      first_d     = '0;
      first_vld_d = 1'b0;
      sat_d       = 1'b0;
    end else begin
      if (enable_i) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + LAT_ONE;
        word_d   = word_q + CNT_W'(1);
        case (state_q)
          IDLE: begin
            // latency_i is ADDR_W wide, so it never exceeds DEPTH-1.
            lq_eff = latency_i;
            lq_d   = latency_i;
            if (latency_i == '0) begin
              state_d = CHECK;
              do_cmp  = 1'b1;
            end else if (latency_i == LAT_ONE) begin
              state_d = CHECK;
            end else begin
              state_d = FILL;
            end
          end
          // wr_ptr equals the write count while filling (Lq < DEPTH).
          FILL: if (wr_ptr_d == lq_q) state_d = CHECK;
          default: do_cmp = 1'b1;
        endcase

        if (do_cmp) begin
          ref_bit     = (lq_eff == '0) ? data_i : mem[wr_ptr_q - lq_eff];
          mismatch    = dec_i ^ ref_bit;
          cmp_valid_d = 1'b1;
          err_d       = mismatch;
          if (mismatch) begin
            if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
            if (!first_vld_q) begin
              // word_q is the write index of this cycle; subtract Lq to name the original bit.
              first_d     = word_q - CNT_W'(lq_eff);
              first_vld_d = 1'b1;
            end
          end else begin
            if (good_q != '1) good_d = good_q + CNT_W'(1);
          end
        end
      end
      sat_d = sat_q | (&good_d) | (&bad_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lq_q        <= '0;
      wr_ptr_q    <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      word_q      <= '0;
      first_q     <= '0;
      first_vld_q <= 1'b0;
      sat_q       <= 1'b0;
      cmp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lq_q        <= lq_d;
      wr_ptr_q    <= wr_ptr_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      word_q      <= word_d;
      first_q     <= first_d;
      first_vld_q <= first_vld_d;
      sat_q       <= sat_d;
      cmp_valid_q <= cmp_valid_d;
      err_q       <= err_d;
    end
  end

  // History is never reset; FILL guarantees only written entries are read.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= data_i;
  end

  assign good_ct_o       = good_q;
  assign bad_ct_o        = bad_q;
  assign word_ct_o       = word_q;
  assign cmp_valid_o     = cmp_valid_q;
  assign err_o           = err_q;
  assign first_err_o     = first_q;
  assign first_err_vld_o = first_vld_q;
  assign sat_o           = sat_q;

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// tb/tb_viterbi_ber_monitor.sv - self-checking bench for viterbi_ber_monitor
module tb_viterbi_ber_monitor;

  logic        clk;
  logic        rst;
  logic        enable_i;
  logic        data_i;
  logic        dec_i;
  logic [11:0] latency_i;
  logic        clear_i;

  logic [15:0] w_good, w_bad, w_word, w_first;
  logic        w_cv, w_err, w_fvld, w_sat;
  logic [3:0]  n_good, n_bad, n_word, n_first;
  logic        n_cv, n_err, n_fvld, n_sat;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int cv_cnt = 0;
  int stall_cv = 0;

  viterbi_ber_monitor #(.ADDR_W(12), .CNT_W(16)) u_wide (
    .clk(clk), .rst(rst), .enable_i(enable_i), .data_i(data_i), .dec_i(dec_i),
    .latency_i(latency_i), .clear_i(clear_i),
    .good_ct_o(w_good), .bad_ct_o(w_bad), .word_ct_o(w_word),
    .cmp_valid_o(w_cv), .err_o(w_err), .first_err_o(w_first),
    .first_err_vld_o(w_fvld), .sat_o(w_sat)
  );

  viterbi_ber_monitor #(.ADDR_W(12), .CNT_W(4)) u_narrow (
    .clk(clk), .rst(rst), .enable_i(enable_i), .data_i(data_i), .dec_i(dec_i),
    .latency_i(latency_i), .clear_i(clear_i),
    .good_ct_o(n_good), .bad_ct_o(n_bad), .word_ct_o(n_word),
    .cmp_valid_o(n_cv), .err_o(n_err), .first_err_o(n_first),
    .first_err_vld_o(n_fvld), .sat_o(n_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: unbounded history of written bits, compare bit k against
  // the decoded bit arriving Lq enable cycles later.
  bit     hist[$];
  bit     m_active;
  int     m_lq;
  int     m_n;
  longint m_good, m_bad;
  bit     m_fvld;
  int     m_first;
  bit     m_cv, m_err;
  bit     m_en_last;

  task automatic m_reset();
    hist.delete();
    m_active = 0; m_lq = 0; m_n = 0; m_good = 0; m_bad = 0;
    m_fvld = 0; m_first = 0; m_cv = 0; m_err = 0;
  endtask

  initial begin
    bit rb;
    m_reset();
    m_en_last = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst || clear_i) begin
        m_reset();
        m_en_last = 0;
      end else begin
        m_cv = 0; m_err = 0;
        m_en_last = enable_i;
        if (enable_i) begin
          if (!m_active) begin
            m_active = 1;
            m_lq = int'(latency_i);
            hist.delete();
          end
          hist.push_back(data_i);
          if (m_n >= m_lq) begin
            rb = hist[m_n - m_lq];
            m_cv = 1;
            m_err = (dec_i != rb);
            if (m_err) begin
              m_bad++;
              if (!m_fvld) begin
                m_fvld = 1;
                m_first = m_n - m_lq;
              end
            end else begin
              m_good++;
            end
          end
          m_n++;
        end
      end
    end
  end

  function automatic longint clip(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_inst(input string nm, input int w,
                            input longint g, input longint b, input longint wc, input longint fe,
                            input logic cv, input logic er, input logic fv, input logic st);
    longint mx;
    mx = (longint'(1) << w) - 1;
    chk({nm, ".good"},  g,  clip(m_good, mx));
    chk({nm, ".bad"},   b,  clip(m_bad, mx));
    chk({nm, ".word"},  wc, longint'(m_n) % (mx + 1));
    chk({nm, ".first"}, fe, longint'(m_first) % (mx + 1));
    chk({nm, ".cv"},    longint'(cv), longint'(m_cv));
    chk({nm, ".err"},   longint'(er), longint'(m_err));
    chk({nm, ".fvld"},  longint'(fv), longint'(m_fvld));
    chk({nm, ".sat"},   longint'(st), longint'((m_good >= mx) || (m_bad >= mx)));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_inst("wide", 16, w_good, w_bad, w_word, w_first, w_cv, w_err, w_fvld, w_sat);
      check_inst("narrow", 4, n_good, n_bad, n_word, n_first, n_cv, n_err, n_fvld, n_sat);
      if (w_err) err_cnt++;
      if (w_cv) cv_cnt++;
      if (w_cv && !m_en_last) stall_cv++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1; enable_i = 1; data_i = 1; dec_i = 0;
    tick();
    clear_i = 0; enable_i = 0;
  endtask

  // Stream n enabled bits with latency l; dec_i is the l-delayed copy (bit flip
  // inverted in that copy), or ~data_i when inv; stall gives 7 on / 5 off.
  task automatic run_stream(input int l, input int n, input int flip, input bit inv, input bit stall);
    bit s[];
    int i;
    int cyc;
    s = new[n];
    i = 0;
    cyc = 0;
    latency_i = 12'(l);
    while (i < n) begin
      if (stall && (cyc % 12) >= 7) begin
        enable_i = 0;
        data_i = 1'($urandom_range(0, 1));
        dec_i = 1'($urandom_range(0, 1));
      end else begin
        s[i] = 1'($urandom_range(0, 1));
        enable_i = 1;
        data_i = s[i];
        if (inv) dec_i = ~s[i];
        else if (i >= l) dec_i = s[i - l] ^ ((i - l) == flip);
        else dec_i = 1'($urandom_range(0, 1));
        if (i == 50) latency_i = 12'd7;
        i++;
      end
      cyc++;
      tick();
    end
    enable_i = 0;
  endtask

  initial begin
    rst = 0; enable_i = 0; data_i = 0; dec_i = 0; latency_i = 0; clear_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.good", w_good, 0);
    chk("rst.word", w_word, 0);
    chk("rst.cv", w_cv, 0);
    chk("rst.sat", w_sat, 0);
    rst = 1;

    // mid-stream asynchronous reset, then restart with L=2
    run_stream(2, 5, -1, 1, 0);
    chk("pre_rst.word", w_word, 5);
    #2 rst = 0;
    #1;
    chk("async_rst.word", w_word, 0);
    chk("async_rst.good", w_good, 0);
    chk("async_rst.bad", w_bad, 0);
    chk("async_rst.fvld", w_fvld, 0);
    tick();
    rst = 1;
    run_stream(2, 10, -1, 0, 0);
    chk("restart.good", w_good, 8);
    chk("restart.bad", w_bad, 0);
    chk("restart.word", w_word, 10);

    // aligned stream, L=4 (latency change mid-stream must be ignored)
    do_clear();
    run_stream(4, 256, -1, 0, 0);
    chk("aligned.good", w_good, 252);
    chk("aligned.bad", w_bad, 0);
    chk("aligned.word", w_word, 256);
    chk("aligned.fvld", w_fvld, 0);
    chk("aligned.n_good", n_good, 15);
    chk("aligned.n_sat", n_sat, 1);
    chk("aligned.n_word", n_word, 0);

    // single error on bit 100
    do_clear();
    err_cnt = 0;
    run_stream(4, 256, 100, 0, 0);
    tick();
    chk("single.bad", w_bad, 1);
    chk("single.good", w_good, 251);
    chk("single.first", w_first, 100);
    chk("single.fvld", w_fvld, 1);
    chk("single.err_pulses", err_cnt, 1);

    // bypass L=0, every decoded bit inverted
    do_clear();
    run_stream(0, 10, -1, 1, 0);
    chk("bypass.bad", w_bad, 10);
    chk("bypass.good", w_good, 0);
    chk("bypass.first", w_first, 0);
    chk("bypass.fvld", w_fvld, 1);

    // stalls, L=3
    do_clear();
    tick();
    cv_cnt = 0;
    stall_cv = 0;
    run_stream(3, 60, -1, 0, 1);
    tick();
    chk("stall.bad", w_bad, 0);
    chk("stall.good", w_good, 57);
    chk("stall.word", w_word, 60);
    chk("stall.cv_pulses", cv_cnt, 57);
    chk("stall.cv_in_stall", stall_cv, 0);

    // saturation on the 4-bit instance, then clear
    do_clear();
    run_stream(1, 20, -1, 0, 0);
    chk("sat.n_good", n_good, 15);
    chk("sat.n_sat", n_sat, 1);
    chk("sat.n_bad", n_bad, 0);
    chk("sat.w_good", w_good, 19);
    chk("sat.w_sat", w_sat, 0);
    do_clear();
    chk("clr.n_good", n_good, 0);
    chk("clr.n_sat", n_sat, 0);
    chk("clr.n_word", n_word, 0);
    chk("clr.w_good", w_good, 0);
    chk("clr.w_word", w_word, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
